// File: rtl/adder_tree_pipelined.sv
// -----------------------------------------------------------------------------
// adder_tree_pipelined
//
// Fully pipelined binary adder tree. It sums N = 2^LEVELS leaf operands of
// ADDER_WIDTH bits each and registers every tree level. A valid/ready stream
// handshake is provided, and an optional running accumulation follows the
// final tree level.
//
// Pipeline: S0 (input register) -> S1..S_LEVELS (one register per tree level)
//           -> S_OUT (output / accumulate register).
// Latency : a beat accepted at edge t is presented with out_valid=1 after
//           edge t+LEVELS+1.
// Stall   : one global advance enable, advance = !out_valid || out_ready.
//
// Ports
//   clk       in   1              rising-edge clock
//   rst_n     in   1              asynchronous active-low reset
//   in_data   in   N*ADDER_WIDTH  packed leaves, leaf i at [i*ADDER_WIDTH +: ADDER_WIDTH]
//   in_acc    in   1              add this beat's sum onto the previous output sum
//   in_valid  in   1              input beat valid
//   in_ready  out  1              beat can be accepted this cycle (= advance)
//   out_sum   out  OUT_W          result, OUT_W = ADDER_WIDTH+LEVELS+ACC_BITS
//   out_valid out  1              out_sum valid
//   out_ready in   1              downstream accepts out_sum
// -----------------------------------------------------------------------------
module adder_tree_pipelined #(
    parameter int ADDER_WIDTH = 6,
    parameter int LEVELS      = 3,
    parameter int ACC_BITS    = 4,
    parameter int SIGNED      = 0,
    localparam int N          = 1 << LEVELS,
    localparam int OUT_W      = ADDER_WIDTH + LEVELS + ACC_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N*ADDER_WIDTH-1:0] in_data,
    input  logic                     in_acc,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OUT_W-1:0]         out_sum,
    output logic                     out_valid,
    input  logic                     out_ready
);

    // Bit offset of tree level k inside the flat tree register. Level j holds
    // N>>j values of ADDER_WIDTH+j bits each, levels stored back to back.
    function automatic int lvl_off(input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) begin
            o = o + (N >> j) * (ADDER_WIDTH + j);
        end
        return o;
    endfunction

    localparam int  TREE_BITS = lvl_off(LEVELS + 1);
    localparam int  TOP_W     = ADDER_WIDTH + LEVELS;
    localparam int  TOP_OFF   = lvl_off(LEVELS);
    localparam bit  IS_SIGNED = (SIGNED != 0);

    // Tree data for every level, plus per-stage valid and travelling in_acc.
    logic [TREE_BITS-1:0] tree_q, tree_d;
    logic [LEVELS:0]      vld_q,  vld_d;
    logic [LEVELS:0]      acc_q,  acc_d;
    logic [OUT_W-1:0]     out_sum_q,   out_sum_d;
    logic                 out_valid_q, out_valid_d;

    logic                 adv_s;
    logic [TOP_W-1:0]     top_s;
    logic [OUT_W-1:0]     top_ext_s;

    assign adv_s    = !out_valid_q || out_ready;
    assign in_ready = adv_s;

    // Level 0: input register loads only on an accepted beat.
    assign tree_d[0 +: N*ADDER_WIDTH] = (adv_s && in_valid) ? in_data
                                                            : tree_q[0 +: N*ADDER_WIDTH];

    // Levels 1..LEVELS: pairwise sums, each one bit wider than its operands,
    // so no level can overflow. A level loads only when the stage feeding it
    // holds a valid beat, so bubbles leave the data untouched.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int WI  = ADDER_WIDTH + k - 1;
        localparam int CNT = N >> k;
        localparam int OI  = lvl_off(k - 1);
        localparam int OO  = lvl_off(k);

        logic [CNT*(WI+1)-1:0] sum_s;

        for (genvar i = 0; i < CNT; i++) begin : g_add
            logic [WI-1:0] a_s;
            logic [WI-1:0] b_s;
            logic          a_ext_s;
            logic          b_ext_s;

            assign a_s     = tree_q[OI + (2*i)   * WI +: WI];
            assign b_s     = tree_q[OI + (2*i+1) * WI +: WI];
            assign a_ext_s = IS_SIGNED ? a_s[WI-1] : 1'b0;
            assign b_ext_s = IS_SIGNED ? b_s[WI-1] : 1'b0;
            assign sum_s[i*(WI+1) +: WI+1] = {a_ext_s, a_s} + {b_ext_s, b_s};
        end

        assign tree_d[OO +: CNT*(WI+1)] = (adv_s && vld_q[k-1]) ? sum_s
                                                                : tree_q[OO +: CNT*(WI+1)];
    end

    assign top_s = tree_q[TOP_OFF +: TOP_W];

    // Extend the final tree sum to the output width using operand signedness.
    always_comb begin
        top_ext_s = {OUT_W{1'b0}};
        if (IS_SIGNED) begin
            top_ext_s = OUT_W'($signed(top_s));
        end else begin
            top_ext_s = OUT_W'(top_s);
        end
    end

    // Next state of stage valid bits and the in_acc sideband travelling with each beat.
    always_comb begin
        vld_d = vld_q;
        acc_d = acc_q;
        if (adv_s) begin
            vld_d    = {vld_q[LEVELS-1:0], in_valid};
            acc_d[0] = in_valid ? in_acc : acc_q[0];
            for (int k = 1; k <= LEVELS; k++) begin
                acc_d[k] = vld_q[k-1] ? acc_q[k-1] : acc_q[k];
            end
        end else begin
            vld_d = vld_q;
            acc_d = acc_q;
        end
    end

    // Next state of the output / accumulate stage. Accumulation wraps modulo 2^OUT_W.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        if (adv_s) begin
            out_valid_d = vld_q[LEVELS];
            if (vld_q[LEVELS]) begin
                if (acc_q[LEVELS]) begin
                    out_sum_d = out_sum_q + top_ext_s;
                end else begin
                    out_sum_d = top_ext_s;
                end
            end else begin
                out_sum_d = out_sum_q;
            end
        end else begin
            out_valid_d = out_valid_q;
            out_sum_d   = out_sum_q;
        end
    end

    // All pipeline state; reset discards in-flight beats and the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree_q      <= {TREE_BITS{1'b0}};
            vld_q       <= {(LEVELS+1){1'b0}};
            acc_q       <= {(LEVELS+1){1'b0}};
            out_sum_q   <= {OUT_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            tree_q      <= tree_d;
            vld_q       <= vld_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Self-checking bench: an unsigned and a signed instance receive identical
// stimulus; a reference model computes expected sums from the leaf values.
module tb_adder_tree_pipelined;

    localparam int AW = 6;
    localparam int LV = 3;
    localparam int NL = 8;
    localparam int OW = 13;

    logic            clk;
    logic            rst_n;
    logic [NL*AW-1:0] in_data;
    logic            in_acc;
    logic            in_valid;
    logic            out_ready;
    logic            in_ready_u, in_ready_s;
    logic [OW-1:0]   out_sum_u,  out_sum_s;
    logic            out_valid_u, out_valid_s;

    adder_tree_pipelined #(.ADDER_WIDTH(AW), .LEVELS(LV), .ACC_BITS(4), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_acc(in_acc),
        .in_valid(in_valid), .in_ready(in_ready_u), .out_sum(out_sum_u),
        .out_valid(out_valid_u), .out_ready(out_ready)
    );

    adder_tree_pipelined #(.ADDER_WIDTH(AW), .LEVELS(LV), .ACC_BITS(4), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_acc(in_acc),
        .in_valid(in_valid), .in_ready(in_ready_s), .out_sum(out_sum_s),
        .out_valid(out_valid_s), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [OW-1:0] exp_u_q[$];
    logic [OW-1:0] exp_s_q[$];
    int            acc_u = 0;
    int            acc_s = 0;
    logic [OW-1:0] last_u, last_s;
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_u, prev_s;
    logic          accepted;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NL*AW-1:0] rep(input logic [AW-1:0] v);
        logic [NL*AW-1:0] d;
        for (int i = 0; i < NL; i++) d[i*AW +: AW] = v;
        return d;
    endfunction

    // Model: record the expected output of an accepted beat.
    task automatic model_push(input logic [NL*AW-1:0] d, input logic a);
        int su, ss;
        logic [AW-1:0] leaf;
        su = 0;
        ss = 0;
        for (int i = 0; i < NL; i++) begin
            leaf = d[i*AW +: AW];
            su   = su + int'(leaf);
            ss   = ss + int'($signed(leaf));
        end
        acc_u = a ? (acc_u + su) : su;
        acc_s = a ? (acc_s + ss) : ss;
        acc_u = acc_u & 32'h1FFF;
        acc_s = acc_s & 32'h1FFF;
        exp_u_q.push_back(OW'(acc_u));
        exp_s_q.push_back(OW'(acc_s));
    endtask

    task automatic model_clear();
        exp_u_q.delete();
        exp_s_q.delete();
        acc_u      = 0;
        acc_s      = 0;
        prev_stall = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, check, let the rising edge sample.
    task automatic step(input logic v, input logic a, input logic [NL*AW-1:0] d, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_acc    = a;
        in_data   = d;
        out_ready = r;
        #1;
        if (prev_stall) begin
            check_eq("hold_u", out_sum_u, prev_u);
            check_eq("hold_s", out_sum_s, prev_s);
        end
        check_eq("in_ready_u", in_ready_u, !out_valid_u || out_ready);
        check_eq("valid_match", out_valid_s, out_valid_u);
        if (out_valid_u && out_ready) begin
            check_eq("sb_nonempty", (exp_u_q.size() > 0), 1);
            if (exp_u_q.size() > 0) begin
                last_u = out_sum_u;
                last_s = out_sum_s;
                check_eq("sum_u", out_sum_u, exp_u_q.pop_front());
                check_eq("sum_s", out_sum_s, exp_s_q.pop_front());
            end
        end
        accepted = in_valid && in_ready_u;
        if (accepted) model_push(in_data, in_acc);
        prev_stall = out_valid_u && !out_ready;
        prev_u     = out_sum_u;
        prev_s     = out_sum_s;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_u_q.size() > 0; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
        end
        check_eq("drained", exp_u_q.size(), 0);
    endtask

    initial begin
        int lat;
        int b;
        logic [NL*AW-1:0] d;
        logic [3:0] rpat;

        rst_n     = 1'b0;
        in_data   = '0;
        in_acc    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        last_u    = '0;
        last_s    = '0;
        prev_u    = '0;
        prev_s    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_valid", out_valid_u, 0);
        check_eq("rst_sum_u", out_sum_u, 0);
        check_eq("rst_sum_s", out_sum_s, 0);
        check_eq("rst_ready", in_ready_u, 1);

        // Single beat, latency and one-cycle valid
        step(1'b1, 1'b0, rep(6'd63), 1'b1);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            if (out_valid_u) lat = i;
        end
        check_eq("latency", lat, 5);
        check_eq("single_u", last_u, 504);
        step(1'b0, 1'b0, '0, 1'b1);
        check_eq("valid_one_cycle", out_valid_u, 0);

        // Most negative leaves, then alternating 31/-32
        step(1'b1, 1'b0, rep(6'b100000), 1'b1);
        drain();
        check_eq("neg_s", last_s, 13'h1F00);
        check_eq("neg_u", last_u, 256);
        for (int i = 0; i < NL; i++) d[i*AW +: AW] = (i % 2 == 0) ? 6'd31 : 6'b100000;
        step(1'b1, 1'b0, d, 1'b1);
        drain();
        check_eq("alt_s", last_s, 13'h1FFC);

        // Accumulate chain
        step(1'b1, 1'b0, rep(6'd1), 1'b1);
        step(1'b1, 1'b1, rep(6'd1), 1'b1);
        step(1'b1, 1'b1, rep(6'd1), 1'b1);
        step(1'b1, 1'b0, rep(6'd2), 1'b1);
        drain();
        check_eq("acc_restart", last_u, 16);

        // Wrap of the accumulator
        for (int i = 0; i < 17; i++) step(1'b1, (i != 0), rep(6'd63), 1'b1);
        drain();
        check_eq("wrap_u", last_u, 376);

        // Backpressure, out_ready pattern 1,0,0,1
        rpat = 4'b1001;
        b = 0;
        for (int c = 0; c < 200 && (b < 8 || exp_u_q.size() > 0); c++) begin
            step(b < 8, 1'b0, rep(6'(b + 1)), rpat[c % 4]);
            if (accepted) b++;
        end
        check_eq("bp_beats", b, 8);
        check_eq("bp_last", last_u, 64);
        drain();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 48'({$urandom(), $urandom()}), $urandom_range(0, 2) != 0);
        end
        drain();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rep(6'd5), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0);
        check_eq("pre_rst_valid", out_valid_u, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", out_valid_u, 0);
        check_eq("arst_sum_u", out_sum_u, 0);
        check_eq("arst_sum_s", out_sum_s, 0);
        model_clear();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b1, rep(6'd1), 1'b1);
        drain();
        check_eq("post_rst_acc_u", last_u, 8);
        check_eq("post_rst_acc_s", last_s, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
